rr_onehot_arbiter: RTL

Round-robin arbiter that shares one downstream resource between N requesters. It issues a registered grant vector that is always either all-zero or exactly one-hot. The grant is held until the owner signals done, drops its request, or exceeds a hold limit. It sits in front of the shared datapath, and its grant bus is the vector our one-hot checker monitors.

---
 rtl/rr_onehot_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, release on done, request drop or hold limit.
// The rotating priority pointer moves just past the previous owner on each release.
module rr_onehot_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDW      = 3,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNTW     = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic [N-1:0]   req_i,
    input  logic           done_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_id_o,
    output logic           busy_o,
    output logic           timeout_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  grant_id_q;
    logic [CNTW-1:0] cnt_q;
    logic [N-1:0]    grant_q;
    logic            busy_q;
    logic            timeout_q;

    logic            pick_vld;
    logic [IDW-1:0]  pick_idx;
    int unsigned     scan_idx;
    logic            owner_req;
    logic            hold_last;
    logic [IDW-1:0]  ptr_nxt;

    // Scan from the pointer upwards with wrap; the first set request wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = (32'(ptr_q) + k) % N;
            if (!pick_vld && req_i[scan_idx[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        owner_req = req_i[grant_id_q];
        hold_last = (cnt_q == CNTW'(MAX_HOLD - 1));
        ptr_nxt   = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + IDW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_id_q <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_i && pick_vld) begin
                        state_q    <= StBusy;
                        grant_q    <= N'(1) << pick_idx;
                        grant_id_q <= pick_idx;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                StBusy: begin
                    if (done_i || !owner_req || hold_last) begin
                        state_q    <= StIdle;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        busy_q     <= 1'b0;
                        ptr_q      <= ptr_nxt;
                        // Only a pure hold-limit release is reported as a timeout.
                        timeout_q  <= !done_i && owner_req;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule
